fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer.
// Steps the PC through the MAR and memory into the IR, then increments the PC.
// Every control output is decoded from the registered state only, so no input
// reaches an output without passing through a clock edge. A memory access that
// never completes is caught by a bounded wait counter, which moves the
// sequencer into FAULT. Software leaves FAULT by pulsing CLEAR.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 HALT,
    input  logic                 CLEAR,
    input  logic                 MEM_READY,
    output logic                 PC_ENABLE,
    output logic                 PC_RW,
    output logic                 PC_COUNT,
    output logic                 MAR_ENABLE,
    output logic                 MAR_RW,
    output logic                 MEM_ENABLE,
    output logic                 MEM_RW,
    output logic                 IR_ENABLE,
    output logic                 IR_RW,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERROR,
    output logic [2:0]           STATE,
    output logic [CNT_WIDTH-1:0] FETCH_COUNT
);

    // The wait counter is only 4 bits wide, so the timeout must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT must be in 1..15");
    end

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPcToMar = 3'd1,
        StMemWait = 3'd2,
        StMemToIr = 3'd3,
        StPcInc   = 3'd4,
        StFault   = 3'd5
    } state_e;

    // Counter value seen on the last MEM_WAIT cycle that is still tolerated.
    localparam logic [3:0] WaitLast = 4'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // A new fetch may begin only when it is requested and not blocked.
    logic fetch_go;
    assign fetch_go = START & ~HALT;

    // State, wait counter and fetch counter registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. HALT is only looked at in IDLE and PC_INC, so a fetch
    // that has already started always runs to completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (fetch_go) begin
                    state_d = StPcToMar;
                end
            end
            StPcToMar: begin
                state_d = StMemWait;
            end
            StMemWait: begin
                // Data arriving on the last tolerated cycle still wins over the timeout.
                if (MEM_READY) begin
                    state_d = StMemToIr;
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end
            end
            StMemToIr: begin
                state_d = StPcInc;
            end
            StPcInc: begin
                state_d = fetch_go ? StPcToMar : StIdle;
            end
            StFault: begin
                if (CLEAR) begin
                    state_d = StIdle;
                end
            end
            // The unused codes 6 and 7 recover to IDLE.
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Wait counter: zero everywhere outside MEM_WAIT, so it is always zero on
    // entry. It saturates instead of wrapping.
    always_comb begin
        wait_d = 4'd0;
        if (state_q == StMemWait) begin
            wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
        end
    end

    // Completed-fetch counter: counts each edge that leaves PC_INC and wraps
    // naturally at all-ones.
    always_comb begin
        count_d = count_q;
        if (state_q == StPcInc) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Moore output decode. At most one unit is driving the bus (ENABLE with
    // RW=1) in any state.
    always_comb begin
        PC_ENABLE  = 1'b0;
        PC_RW      = 1'b0;
        PC_COUNT   = 1'b0;
        MAR_ENABLE = 1'b0;
        MAR_RW     = 1'b0;
        MEM_ENABLE = 1'b0;
        MEM_RW     = 1'b0;
        IR_ENABLE  = 1'b0;
        IR_RW      = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        ERROR      = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StPcToMar: begin
                // The PC drives the bus and the MAR loads from it.
                PC_ENABLE  = 1'b1;
                PC_RW      = 1'b1;
                MAR_ENABLE = 1'b1;
                MAR_RW     = 1'b0;
                BUSY       = 1'b1;
            end
            StMemWait: begin
                MEM_ENABLE = 1'b1;
                MEM_RW     = 1'b1;
                BUSY       = 1'b1;
            end
            StMemToIr: begin
                // Memory keeps driving the bus while the IR captures the data.
                MEM_ENABLE = 1'b1;
                MEM_RW     = 1'b1;
                IR_ENABLE  = 1'b1;
                IR_RW      = 1'b0;
                BUSY       = 1'b1;
            end
            StPcInc: begin
                // The PC increments internally; PC_ENABLE stays low so the bus is not driven.
                PC_RW    = 1'b1;
                PC_COUNT = 1'b1;
                BUSY     = 1'b1;
                DONE     = 1'b1;
            end
            StFault: begin
                ERROR = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign STATE       = state_q;
    assign FETCH_COUNT = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer.
// The stimulus process drives one cycle at a time. For each cycle it queues the
// complete output vector expected after that edge. A separate monitor pops one
// entry every falling edge and compares it with the DUT outputs.
module tb_fetch_sequencer;

    logic        CLOCK;
    logic        RESET;
    logic        START;
    logic        HALT;
    logic        CLEAR;
    logic        MEM_READY;
    logic        PC_ENABLE, PC_RW, PC_COUNT;
    logic        MAR_ENABLE, MAR_RW;
    logic        MEM_ENABLE, MEM_RW;
    logic        IR_ENABLE, IR_RW;
    logic        BUSY, DONE, ERROR;
    logic [2:0]  STATE;
    logic [15:0] FETCH_COUNT;

    fetch_sequencer #(
        .TIMEOUT  (15),
        .CNT_WIDTH(16)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .START      (START),
        .HALT       (HALT),
        .CLEAR      (CLEAR),
        .MEM_READY  (MEM_READY),
        .PC_ENABLE  (PC_ENABLE),
        .PC_RW      (PC_RW),
        .PC_COUNT   (PC_COUNT),
        .MAR_ENABLE (MAR_ENABLE),
        .MAR_RW     (MAR_RW),
        .MEM_ENABLE (MEM_ENABLE),
        .MEM_RW     (MEM_RW),
        .IR_ENABLE  (IR_ENABLE),
        .IR_RW      (IR_RW),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERROR      (ERROR),
        .STATE      (STATE),
        .FETCH_COUNT(FETCH_COUNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        string       name;
        logic [30:0] vec;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_seen = 0;
    int          exp_done = 0;
    logic [30:0] act;

    assign act = {STATE, PC_ENABLE, PC_RW, PC_COUNT, MAR_ENABLE, MAR_RW, MEM_ENABLE, MEM_RW,
                  IR_ENABLE, IR_RW, BUSY, DONE, ERROR, FETCH_COUNT};

    // Control word per state, written out by hand from the state table:
    // {pc_en, pc_rw, pc_cnt, mar_en, mar_rw, mem_en, mem_rw, ir_en, ir_rw, busy, done, error}
    function automatic logic [11:0] ctrl_of(input logic [2:0] st);
        case (st)
            3'd1:    return 12'b110_10_00_00_100;
            3'd2:    return 12'b000_00_11_00_100;
            3'd3:    return 12'b000_00_11_10_100;
            3'd4:    return 12'b011_00_00_00_110;
            3'd5:    return 12'b000_00_00_00_001;
            default: return 12'b000_00_00_00_000;
        endcase
    endfunction

    function automatic logic [30:0] mk(input logic [2:0] st, input logic [15:0] cnt);
        return {st, ctrl_of(st), cnt};
    endfunction

    // Monitor: counts DONE pulses and checks one queued expectation per cycle.
    always @(negedge CLOCK) begin
        exp_t e;
        if (DONE === 1'b1) done_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act !== e.vec) begin
                bad++;
                $display("FAIL %s: got state=%0d ctrl=%b cnt=%0d, want state=%0d ctrl=%b cnt=%0d",
                         e.name, act[30:28], act[27:16], act[15:0],
                         e.vec[30:28], e.vec[27:16], e.vec[15:0]);
            end
        end
    end

    // Drive inputs for one cycle and queue the outputs expected after the edge.
    task automatic step(input string name, input logic s, input logic h, input logic c,
                        input logic r, input logic [2:0] st, input logic [15:0] cnt);
        exp_t e;
        START     = s;
        HALT      = h;
        CLEAR     = c;
        MEM_READY = r;
        @(posedge CLOCK);
        #1;
        e.name = name;
        e.vec  = mk(st, cnt);
        exp_q.push_back(e);
        if (st == 3'd4) exp_done++;
    endtask

    // Immediate comparison, used while reset is asserted.
    task automatic check_now(input string name, input logic [30:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET     = 1'b0;
        START     = 1'b0;
        HALT      = 1'b0;
        CLEAR     = 1'b0;
        MEM_READY = 1'b0;
        #3;
        check_now("reset_state", mk(3'd0, 16'd0));
        @(negedge CLOCK);
        RESET = 1'b1;
        step("post_reset_idle", 0, 0, 0, 0, 3'd0, 16'd0);

        // Single fetch with memory ready on the first wait cycle.
        step("single_pc_to_mar", 1, 0, 0, 0, 3'd1, 16'd0);
        step("single_mem_wait",  0, 0, 0, 0, 3'd2, 16'd0);
        step("single_mem_to_ir", 0, 0, 0, 1, 3'd3, 16'd0);
        step("single_pc_inc",    0, 0, 0, 0, 3'd4, 16'd0);
        step("single_idle",      0, 0, 0, 0, 3'd0, 16'd1);

        // Back-to-back fetches with START held high.
        for (int k = 0; k < 3; k++) begin
            step("b2b_pc_to_mar", 1, 0, 0, 1, 3'd1, 16'(1 + k));
            step("b2b_mem_wait",  1, 0, 0, 1, 3'd2, 16'(1 + k));
            step("b2b_mem_to_ir", 1, 0, 0, 1, 3'd3, 16'(1 + k));
            step("b2b_pc_inc",    1, 0, 0, 1, 3'd4, 16'(1 + k));
        end
        step("b2b_idle", 0, 0, 0, 0, 3'd0, 16'd4);

        // Memory never ready: 15 wait cycles, then FAULT. START is ignored; CLEAR leaves.
        step("tmo_pc_to_mar", 1, 0, 0, 0, 3'd1, 16'd4);
        step("tmo_wait_first", 0, 0, 0, 0, 3'd2, 16'd4);
        for (int i = 0; i < 14; i++) step("tmo_wait", 0, 0, 0, 0, 3'd2, 16'd4);
        step("tmo_fault",        0, 0, 0, 0, 3'd5, 16'd4);
        step("tmo_fault_start",  1, 0, 0, 0, 3'd5, 16'd4);
        step("tmo_clear_idle",   0, 0, 1, 0, 3'd0, 16'd4);
        step("tmo_idle_stays",   0, 0, 0, 0, 3'd0, 16'd4);

        // Memory ready on the last tolerated wait cycle: data wins over the timeout.
        step("late_pc_to_mar", 1, 0, 0, 0, 3'd1, 16'd4);
        step("late_wait_first", 0, 0, 0, 0, 3'd2, 16'd4);
        for (int i = 0; i < 14; i++) step("late_wait", 0, 0, 0, 0, 3'd2, 16'd4);
        step("late_mem_to_ir", 0, 0, 0, 1, 3'd3, 16'd4);
        step("late_pc_inc",    0, 0, 0, 0, 3'd4, 16'd4);
        step("late_idle",      0, 0, 0, 0, 3'd0, 16'd5);

        // HALT raised mid-fetch: the current fetch finishes, and no new fetch starts until HALT drops.
        step("halt_pc_to_mar", 1, 0, 0, 0, 3'd1, 16'd5);
        step("halt_mem_wait",  1, 0, 0, 0, 3'd2, 16'd5);
        step("halt_mem_to_ir", 1, 1, 0, 1, 3'd3, 16'd5);
        step("halt_pc_inc",    1, 1, 0, 0, 3'd4, 16'd5);
        step("halt_idle",      1, 1, 0, 0, 3'd0, 16'd6);
        step("halt_idle_held", 1, 1, 0, 0, 3'd0, 16'd6);
        step("unhalt_start",   1, 0, 0, 0, 3'd1, 16'd6);
        step("unhalt_wait",    0, 0, 0, 0, 3'd2, 16'd6);
        step("unhalt_ir",      0, 0, 0, 1, 3'd3, 16'd6);
        step("unhalt_inc",     0, 0, 0, 0, 3'd4, 16'd6);
        step("unhalt_idle",    0, 0, 0, 0, 3'd0, 16'd7);

        // Reset during MEM_WAIT: outputs clear at once; no DONE; counter back to 0.
        step("rst_pc_to_mar", 1, 0, 0, 0, 3'd1, 16'd7);
        step("rst_mem_wait",  0, 0, 0, 0, 3'd2, 16'd7);
        @(negedge CLOCK);
        #1;
        RESET     = 1'b0;
        MEM_READY = 1'b1;
        #1;
        check_now("rst_async_clear", mk(3'd0, 16'd0));
        @(posedge CLOCK);
        #1;
        check_now("rst_held", mk(3'd0, 16'd0));
        @(negedge CLOCK);
        RESET     = 1'b1;
        MEM_READY = 1'b0;
        step("rst_after_idle", 0, 0, 0, 0, 3'd0, 16'd0);
        step("rst_refetch_1",  1, 0, 0, 0, 3'd1, 16'd0);
        step("rst_refetch_2",  0, 0, 0, 0, 3'd2, 16'd0);
        step("rst_refetch_3",  0, 0, 0, 1, 3'd3, 16'd0);
        step("rst_refetch_4",  0, 0, 0, 0, 3'd4, 16'd0);
        step("rst_refetch_0",  0, 0, 0, 0, 3'd0, 16'd1);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLOCK);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        total++;
        if (done_seen != exp_done) begin
            bad++;
            $display("FAIL done_pulses: got %0d want %0d", done_seen, exp_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
